apb_const_rom: RTL and testbench
================================

APB_CONST_ROM -- requirements
Module: apb_const_rom

Interface
REQ-001 The module SHALL have parameter BASE_ADDR, default 32'h7000_0000: APB address of word 0.
REQ-002 The module SHALL have parameter NUM_WORDS, default 4, range 1..16: number of constant words served.
REQ-003 The module SHALL have parameter WAIT_STATES, default 0, range 0..15: access-phase wait cycles inserted before pready.
REQ-004 Port pclk  input  1  the single clock; all state changes on its rising edge.
REQ-005 Port preset  input  1  reset; asynchronous, active-high.
REQ-006 Port psel  input  1  APB select.
REQ-007 Port penable  input  1  APB access phase.
REQ-008 Port pwrite  input  1  APB direction; 1 = write.
REQ-009 Port paddr  input  32  APB address; one word per address unit.
REQ-010 Port pwdata  input  32  APB write data; ignored.
REQ-011 Port prdata  output  32  read data; valid only while pready=1.
REQ-012 Port pready  output  1  transfer completion.
REQ-013 Port pslverr  output  1  transfer error; valid only while pready=1.

Function
REQ-014 Word index idx = paddr - BASE_ADDR (32-bit unsigned); map: idx 0..NUM_WORDS-1 = CONST_TABLE[idx]; idx NUM_WORDS = RD_CNT; idx NUM_WORDS+1 = ERR_CNT.
REQ-015 Constants are 2.62 unsigned fixed point, high word first: pi = C90FDAA2, 2168C234; e = ADF85458, A2BB4A9A.
REQ-016 FSM states: IDLE, WAIT, ACCESS.
REQ-017 IDLE -> WAIT on psel=1 & penable=0 when WAIT_STATES>0, loading wait counter with WAIT_STATES; IDLE -> ACCESS on the same condition when WAIT_STATES=0.
REQ-018 The FSM SHALL latch paddr and pwrite on the IDLE exit edge; later changes to them are ignored.
REQ-019 WAIT decrements the counter each cycle; WAIT -> ACCESS when counter = 1.
REQ-020 With the setup cycle as cycle 0, pready SHALL be 1 exactly in cycle WAIT_STATES+1, for one cycle; ACCESS -> IDLE unconditionally.
REQ-021 pready, prdata and pslverr SHALL be driven from registers only (no combinational path from APB inputs).
REQ-022 pslverr=1 and prdata=0 in ACCESS if latched pwrite=1 or idx > NUM_WORDS+1 (this includes paddr < BASE_ADDR via wrap-around).
REQ-023 Outside ACCESS: pready=0, pslverr=0, prdata=0.
REQ-024 RD_CNT SHALL increment on each ACCESS with pslverr=0; ERR_CNT on each ACCESS with pslverr=1; both SHALL saturate at FFFFFFFF.
REQ-025 A read of RD_CNT SHALL return its value before that transfer's own increment.
REQ-026 psel=0 while in WAIT SHALL abort to IDLE: no pready, no counter update.
REQ-027 psel=1 & penable=1 seen in IDLE (protocol violation) SHALL be ignored.

Reset
REQ-028 preset=1 SHALL immediately force FSM=IDLE, wait counter=0, RD_CNT=0, ERR_CNT=0, prdata=0, pready=0, pslverr=0, including mid-transfer.
REQ-029 The first transfer after preset falls SHALL be accepted with normal latency.

Structure
REQ-030 Package apb_const_pkg SHALL hold: the FSM state enum, MAX_WORDS=16, and CONST_TABLE[0:15] (entries 0..3 per REQ-015, remainder 0).
REQ-031 Sub-module apb_sat_counter (32-bit, enable, saturating, async active-high reset) SHALL be instantiated twice, once for RD_CNT and once for ERR_CNT.

Verification
REQ-032 Bench: defaults, reads at 7000_0000..7000_0003 -> C90FDAA2, 2168C234, ADF85458, A2BB4A9A; pready in cycle 1; pslverr=0.
REQ-033 Bench: WAIT_STATES=3, read 7000_0000 -> pready=0 in cycles 1..3, pready=1 with C90FDAA2 in cycle 4.
REQ-034 Bench: write to 7000_0001 and read of 7000_0006 -> pslverr=1 and prdata=0 for each; a following read of 7000_0005 (ERR_CNT) -> 00000002.
REQ-035 Bench: after four good reads, read 7000_0004 (RD_CNT) -> 00000004; a following RD_CNT read -> 00000005.
REQ-036 Bench: read 6FFF_FFFF -> pslverr=1.
REQ-037 Bench: WAIT_STATES=3, drop psel in cycle 2 -> no pready, counters unchanged; assert preset during WAIT -> all outputs 0 immediately, counters 0.

Source files
------------

// File: rtl/apb_const_pkg.sv
// Shared types and constant table for the APB constant ROM.
// Constants are 2.62 unsigned fixed point, stored high word first.
package apb_const_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_t;

  localparam int MAX_WORDS = 16;

  localparam logic [31:0] CONST_TABLE [0:MAX_WORDS-1] = '{
    32'hC90F_DAA2, 32'h2168_C234,   // pi
    32'hADF8_5458, 32'hA2BB_4A9A,   // e
    32'h0, 32'h0, 32'h0, 32'h0,
    32'h0, 32'h0, 32'h0, 32'h0,
    32'h0, 32'h0, 32'h0, 32'h0
  };

endpackage

// File: rtl/apb_sat_counter.sv
// Free-running event counter that sticks at all-ones instead of wrapping.
module apb_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (en && count != '1)
      count <= count + W'(1);
  end

endmodule

// File: rtl/apb_const_rom.sv
// Read-only APB slave serving a small constant table plus good/error
// transfer counters, with a programmable number of access wait states.
module apb_const_rom
  import apb_const_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h7000_0000,
  parameter int          NUM_WORDS   = 4,
  parameter int          WAIT_STATES = 0
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  localparam logic [3:0]  WS      = 4'(WAIT_STATES);
  localparam logic [31:0] N_WORDS = 32'(NUM_WORDS);

  state_t      state;
  logic [3:0]  wcnt;
  logic [31:0] lat_addr;
  logic        lat_wr;
  logic [31:0] rd_cnt, err_cnt;

  logic [31:0] sel_idx, sel_data;
  logic        sel_wr, sel_err, setup, go_access;

  // Write data is never stored; reduce it so the port is not flagged unused.
  logic unused_wdata;
  assign unused_wdata = ^pwdata;

  assign setup = psel && !penable;

  // In IDLE the address is still on the bus (zero-wait case); afterwards
  // only the copy latched at the setup edge is trusted.
  always_comb begin
    sel_idx  = ((state == S_IDLE) ? paddr : lat_addr) - BASE_ADDR;
    sel_wr   = (state == S_IDLE) ? pwrite : lat_wr;
    sel_err  = sel_wr || (sel_idx > N_WORDS + 32'd1);
    sel_data = err_cnt;
    if (sel_idx < N_WORDS)
      sel_data = CONST_TABLE[sel_idx[3:0]];
    else if (sel_idx == N_WORDS)
      sel_data = rd_cnt;
    go_access = (state == S_IDLE && setup && WS == 4'd0) ||
                (state == S_WAIT && psel && wcnt == 4'd1);
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state    <= S_IDLE;
      wcnt     <= 4'd0;
      lat_addr <= '0;
      lat_wr   <= 1'b0;
      prdata   <= '0;
      pready   <= 1'b0;
      pslverr  <= 1'b0;
    end else begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
      case (state)
        S_IDLE: begin
          if (setup) begin
            lat_addr <= paddr;
            lat_wr   <= pwrite;
            if (WS == 4'd0) begin
              state <= S_ACCESS;
            end else begin
              state <= S_WAIT;
              wcnt  <= WS;
            end
          end
        end
        S_WAIT: begin
          if (!psel) begin
            state <= S_IDLE;
            wcnt  <= 4'd0;
          end else if (wcnt == 4'd1) begin
            state <= S_ACCESS;
            wcnt  <= 4'd0;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        S_ACCESS: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
      // Response is computed one edge early so the outputs stay registered.
      if (go_access) begin
        pready  <= 1'b1;
        pslverr <= sel_err;
        prdata  <= sel_err ? 32'h0 : sel_data;
      end
    end
  end

  // Counters bump as the ACCESS cycle closes, so an RD_CNT read sees the
  // value from before its own increment.
  apb_sat_counter #(.W(32)) u_rd_cnt (
    .clk   (pclk),
    .rst   (preset),
    .en    (state == S_ACCESS && !pslverr),
    .count (rd_cnt)
  );

  apb_sat_counter #(.W(32)) u_err_cnt (
    .clk   (pclk),
    .rst   (preset),
    .en    (state == S_ACCESS && pslverr),
    .count (err_cnt)
  );

endmodule

// File: tb/tb_apb_const_rom.sv
// Randomized bench for apb_const_rom: zero-wait and three-wait instances
// checked against a transfer-level model of the register map and counters.
module tb_apb_const_rom;

  localparam logic [31:0] BASE = 32'h7000_0000;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];

  always #5 pclk = ~pclk;

  apb_const_rom #(.BASE_ADDR(BASE), .NUM_WORDS(4), .WAIT_STATES(0)) u_dut0 (
    .pclk(pclk), .preset(preset), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
    .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0])
  );

  apb_const_rom #(.BASE_ADDR(BASE), .NUM_WORDS(4), .WAIT_STATES(3)) u_dut1 (
    .pclk(pclk), .preset(preset), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
    .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1])
  );

  // Reference model: map contents and per-instance transfer counters.
  logic [31:0] ctab [4] = '{32'hC90F_DAA2, 32'h2168_C234, 32'hADF8_5458, 32'hA2BB_4A9A};
  logic [31:0] rd_m  [2];
  logic [31:0] err_m [2];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
  endtask

  task automatic idle_bus(input int d);
    psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
    paddr[d] = 32'h0; pwdata[d] = 32'h0;
  endtask

  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      output logic [31:0] got);
    logic [31:0] idx, exp_d;
    logic        exp_e;
    int          ws;
    ws    = (d == 0) ? 0 : 3;
    idx   = addr - BASE;
    exp_e = wr || (idx > 32'd5);
    if (exp_e)          exp_d = 32'h0;
    else if (idx < 4)   exp_d = ctab[idx[1:0]];
    else if (idx == 4)  exp_d = rd_m[d];
    else                exp_d = err_m[d];
    @(posedge pclk); #1;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr;
    pwdata[d] = $urandom;
    @(posedge pclk); #1;
    // Bus address/direction wander after setup; the slave must not care.
    penable[d] = 1'b1; paddr[d] = $urandom; pwrite[d] = 1'($urandom);
    for (int k = 1; k <= ws; k++) begin
      chk("wait_pready", 32'(pready[d]), 32'd0);
      @(posedge pclk); #1;
    end
    chk("pready", 32'(pready[d]), 32'd1);
    chk("pslverr", 32'(pslverr[d]), 32'(exp_e));
    chk("prdata", prdata[d], exp_d);
    got = prdata[d];
    idle_bus(d);
    if (exp_e) begin
      if (err_m[d] != 32'hFFFF_FFFF) err_m[d]++;
    end else begin
      if (rd_m[d] != 32'hFFFF_FFFF) rd_m[d]++;
    end
    @(posedge pclk); #1;
    chk("pready_clr", 32'(pready[d]), 32'd0);
    chk("pslverr_clr", 32'(pslverr[d]), 32'd0);
  endtask

  initial begin
    logic [31:0] got, addr;
    int d, r;
    preset = 1'b1;
    idle_bus(0); idle_bus(1);
    rd_m = '{32'h0, 32'h0}; err_m = '{32'h0, 32'h0};
    repeat (3) @(posedge pclk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_pready", 32'(pready[i]), 32'd0);
      chk("rst_prdata", prdata[i], 32'd0);
      chk("rst_pslverr", 32'(pslverr[i]), 32'd0);
    end
    preset = 1'b0;

    // Constant table, then RD_CNT before/after its own increment.
    xfer(0, 1'b0, BASE + 0, got); chk("pi_hi", got, 32'hC90F_DAA2);
    xfer(0, 1'b0, BASE + 1, got); chk("pi_lo", got, 32'h2168_C234);
    xfer(0, 1'b0, BASE + 2, got); chk("e_hi",  got, 32'hADF8_5458);
    xfer(0, 1'b0, BASE + 3, got); chk("e_lo",  got, 32'hA2BB_4A9A);
    xfer(0, 1'b0, BASE + 4, got); chk("rd_cnt4", got, 32'd4);
    xfer(0, 1'b0, BASE + 4, got); chk("rd_cnt5", got, 32'd5);
    // Error cases and ERR_CNT.
    xfer(0, 1'b1, BASE + 1, got);
    xfer(0, 1'b0, BASE + 6, got);
    xfer(0, 1'b0, BASE + 5, got); chk("err_cnt2", got, 32'd2);
    xfer(0, 1'b0, 32'h6FFF_FFFF, got);
    // Wait-state instance.
    xfer(1, 1'b0, BASE + 0, got); chk("ws3_pi_hi", got, 32'hC90F_DAA2);

    // Abort: psel dropped in cycle 2 of a wait-state transfer.
    @(posedge pclk); #1;
    psel[1] = 1'b1; penable[1] = 1'b0; paddr[1] = BASE;
    @(posedge pclk); #1; penable[1] = 1'b1;
    @(posedge pclk); #1; idle_bus(1);
    for (int k = 0; k < 5; k++) begin
      chk("abort_pready", 32'(pready[1]), 32'd0);
      @(posedge pclk); #1;
    end
    xfer(1, 1'b0, BASE + 4, got); chk("abort_rd_cnt", got, 32'd1);
    xfer(1, 1'b0, BASE + 5, got); chk("abort_err_cnt", got, 32'd0);

    // Randomized traffic, with occasional illegal psel&penable in IDLE.
    for (int it = 0; it < 80; it++) begin
      d = int'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        @(posedge pclk); #1;
        psel[d] = 1'b1; penable[d] = 1'b1; paddr[d] = BASE;
        repeat (2) begin
          @(posedge pclk); #1;
          chk("viol_pready", 32'(pready[d]), 32'd0);
        end
        idle_bus(d);
      end
      r = int'($urandom_range(0, 9));
      if (r < 8)       addr = BASE + 32'(r);
      else if (r == 8) addr = BASE - 32'd1 - 32'($urandom_range(0, 100));
      else             addr = $urandom;
      xfer(d, ($urandom_range(0, 4) == 0), addr, got);
      repeat ($urandom_range(0, 2)) @(posedge pclk);
    end

    // Reset in the middle of WAIT: outputs stay low, counters cleared.
    @(posedge pclk); #1;
    psel[1] = 1'b1; penable[1] = 1'b0; paddr[1] = BASE;
    @(posedge pclk); #1; penable[1] = 1'b1;
    @(posedge pclk); #1; preset = 1'b1;
    #1;
    chk("rstw_pready", 32'(pready[1]), 32'd0);
    chk("rstw_prdata", prdata[1], 32'd0);
    idle_bus(1);
    @(posedge pclk); #1; preset = 1'b0;
    rd_m = '{32'h0, 32'h0}; err_m = '{32'h0, 32'h0};
    chk("rstw_pready2", 32'(pready[1]), 32'd0);
    xfer(1, 1'b0, BASE + 4, got); chk("rstw_rd_cnt", got, 32'd0);
    xfer(1, 1'b0, BASE + 5, got); chk("rstw_err_cnt", got, 32'd0);

    // Reset landing in the ACCESS cycle must drop pready without an edge.
    @(posedge pclk); #1;
    psel[0] = 1'b1; penable[0] = 1'b0; paddr[0] = BASE + 2;
    @(posedge pclk); #1; penable[0] = 1'b1;
    chk("rsta_pready_pre", 32'(pready[0]), 32'd1);
    chk("rsta_prdata_pre", prdata[0], 32'hADF8_5458);
    preset = 1'b1;
    #1;
    chk("rsta_pready", 32'(pready[0]), 32'd0);
    chk("rsta_prdata", prdata[0], 32'd0);
    chk("rsta_pslverr", 32'(pslverr[0]), 32'd0);
    idle_bus(0);
    @(posedge pclk); #1; preset = 1'b0;
    rd_m = '{32'h0, 32'h0}; err_m = '{32'h0, 32'h0};
    xfer(0, 1'b0, BASE + 4, got); chk("rsta_rd_cnt", got, 32'd0);
    xfer(0, 1'b0, BASE + 5, got); chk("rsta_err_cnt", got, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
